// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, issues word fetches over a
// req/ack handshake that tolerates wait states, buffers up to two instructions
// in a skid FIFO, and flushes on branch/jump redirects.
// Optional feature: define FETCH_PERF_EN to add perf_fetched/perf_stall counters.
module fetch_unit #(
    parameter int unsigned               ADDRESS_WIDTH = 32,
    parameter int unsigned               DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]  RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_ack,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [DATA_WIDTH-1:0]    id_instr,
    output logic [ADDRESS_WIDTH-1:0] id_pc,
    output logic [ADDRESS_WIDTH-1:0] id_pc_plus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]              perf_fetched,
    output logic [31:0]              perf_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t                    state;
    state_t                    state_next;

    logic [ADDRESS_WIDTH-1:0]  pc;
    logic [ADDRESS_WIDTH-1:0]  req_addr;
    logic [1:0]                count;

    // FIFO slot 0 is always the head; slot 1 is only meaningful when count == 2
    logic [DATA_WIDTH-1:0]     fifo_instr0;
    logic [DATA_WIDTH-1:0]     fifo_instr1;
    logic [ADDRESS_WIDTH-1:0]  fifo_pc0;
    logic [ADDRESS_WIDTH-1:0]  fifo_pc1;

    logic                      push;
    logic                      pop;
    logic [ADDRESS_WIDTH-1:0]  target;

    assign target      = redirect_pc & ~ADDRESS_WIDTH'(3);
    assign push        = (state == RUN) && imem_req && imem_ack && !redirect;
    assign pop         = id_valid && id_ready;

    assign imem_addr   = req_addr;
    assign id_valid    = (count != 2'd0);
    assign id_instr    = fifo_instr0;
    assign id_pc       = fifo_pc0;
    assign id_pc_plus4 = fifo_pc0 + ADDRESS_WIDTH'(4);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and request decode; imem_req depends on registers only
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        unique case (state)
            IDLE: begin
                state_next = RUN;
            end
            RUN: begin
                imem_req = (count < 2'd2);
                if (redirect && imem_req && !imem_ack) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                imem_req = 1'b1;
                // A redirect landing on the flush ack also ends the flush: the
                // stale request is complete, so the new target is fetched next.
                if (imem_ack) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // PC, request address and skid FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            count       <= '0;
            fifo_instr0 <= '0;
            fifo_instr1 <= '0;
            fifo_pc0    <= '0;
            fifo_pc1    <= '0;
        end else if (redirect) begin
            pc    <= target;
            count <= '0;
            // An unacked request keeps its address until the flush ack
            if (!imem_req || imem_ack) begin
                req_addr <= target;
            end
        end else begin
            if (state == FLUSH && imem_ack) begin
                req_addr <= pc;
            end
            if (push) begin
                pc       <= pc + ADDRESS_WIDTH'(4);
                req_addr <= req_addr + ADDRESS_WIDTH'(4);
            end
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        fifo_instr0 <= imem_rdata;
                        fifo_pc0    <= req_addr;
                    end else begin
                        fifo_instr1 <= imem_rdata;
                        fifo_pc1    <= req_addr;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    fifo_instr0 <= fifo_instr1;
                    fifo_pc0    <= fifo_pc1;
                    count       <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        fifo_instr0 <= imem_rdata;
                        fifo_pc0    <= req_addr;
                    end else begin
                        fifo_instr0 <= fifo_instr1;
                        fifo_pc0    <= fifo_pc1;
                        fifo_instr1 <= imem_rdata;
                        fifo_pc1    <= req_addr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // Decode handshake and decode-stall counters, wrapping at 2^32
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (id_valid && id_ready) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (id_valid && !id_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly upstream of the single-cycle decode/execute datapath. Owns the program counter and issues word fetches to the instruction memory over a req/ack handshake that tolerates wait states. It buffers up to two fetched instructions in a skid FIFO and presents them to decode over a valid/ready interface. Branch/jump redirects from the control unit (PCSrc plus target) flush the stage.

## Interface
Parameters:
- `ADDRESS_WIDTH`, default 32: PC and fetch address width.
- `DATA_WIDTH`, default 32: instruction width.
- `RESET_PC`, default 0: first fetch address after reset; must be 4-byte aligned.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  ADDRESS_WIDTH  fetch address; bits [1:0] always 0.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  DATA_WIDTH  fetched instruction.
- `redirect`  in  1  single-cycle pulse: branch taken or jump.
- `redirect_pc`  in  ADDRESS_WIDTH  redirect target; bits [1:0] ignored and treated as 0.
- `id_valid`  out  1  decode outputs hold a valid instruction.
- `id_ready`  in  1  decode accepts this cycle.
- `id_instr`  out  DATA_WIDTH  instruction at FIFO head.
- `id_pc`  out  ADDRESS_WIDTH  address of `id_instr`.
- `id_pc_plus4`  out  ADDRESS_WIDTH  `id_pc + 4`, modulo 2^ADDRESS_WIDTH.

## Operation
- State machine:
  - IDLE: entered on reset.
  - RUN: normal fetching. IDLE -> RUN on the first edge after `rst` deasserts.
  - FLUSH: discarding a stale request. RUN -> FLUSH on `redirect` while `imem_req` is high without `imem_ack`. FLUSH -> RUN on `imem_ack`.
- Registers:
  - `pc`: next address to fetch.
  - `req_addr`: address of the outstanding request.
  - 2-entry FIFO of {instr, pc} with `count` 0..2.
- `imem_req` is decoded from registers only, with no combinational path from any input:
  - IDLE: 0.
  - RUN: 1 when `count` < 2.
  - FLUSH: 1.
- `imem_addr` = `req_addr`.
- Memory protocol: once `imem_req` rises, `imem_req` and `imem_addr` stay stable until `imem_ack`. At most one request is outstanding. `imem_ack` without `imem_req` is ignored.
- Ack in RUN with no redirect:
  - Push {`imem_rdata`, `req_addr`} into the FIFO.
  - `pc` and `req_addr` advance by 4, wrapping modulo 2^ADDRESS_WIDTH.
- Pop on `id_valid && id_ready`. Push and pop in the same cycle leave `count` unchanged.
- `id_valid` = (`count` != 0). The `id_*` outputs show the FIFO head and are stable while `id_valid && !id_ready`.
- Redirect (any state):
  - FIFO cleared, so `id_valid` = 0 next cycle.
  - `pc` and `req_addr` load `{redirect_pc[AW-1:2], 2'b00}`.
  - Data from an ack in the same cycle is discarded.
  - If a request is pending and unacked, enter FLUSH and keep the old `imem_addr` until ack, then discard that data. `req_addr` switches to the target only after the flush ack.
  - A redirect during FLUSH updates the target and stays in FLUSH.
  - A same-cycle `id_valid && id_ready` handshake still counts as consumed by decode.
- Reset mid-operation: all state is cleared immediately (asynchronous). Any in-flight memory response is not tracked; the memory must abort it on reset.

## Timing
- Reset values:
  - Outputs: `imem_req`=0, `imem_addr`=`RESET_PC`, `id_valid`=0, `id_instr`=0, `id_pc`=0, `id_pc_plus4`=4.
  - Internal: `count`=0, `pc`=`RESET_PC`.
- First `imem_req` is high in the first cycle after the first edge following reset release.
- Zero-wait memory (ack in the same cycle as req): data appears on `id_*` one cycle after ack. Sustained throughput is 1 instruction/cycle while `id_ready`=1.
- N wait states: one instruction per N+1 cycles.
- Redirect to first new `imem_req`:
  - Same cycle as ack or no request pending: next cycle.
  - Otherwise: the cycle after the flush ack.
- Decode stalled with `count`=2: `imem_req`=0. Fetch resumes the cycle after a pop.

## Configuration
- `FETCH_PERF_EN` defined: adds outputs `perf_fetched` (32 bits) and `perf_stall` (32 bits).
  - `perf_fetched` counts completed decode handshakes.
  - `perf_stall` counts cycles with `id_valid && !id_ready`.
  - Both reset to 0 and wrap at 2^32.
- Not defined: those ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset release with `RESET_PC`=0, zero-wait memory returning addr|0x13, `id_ready`=1 -> `id_pc` = 0, 4, 8… on consecutive cycles, with `id_pc_plus4` = `id_pc`+4.
- Memory with 2 wait states -> `imem_addr` held stable across the wait cycles; one `id_valid` pulse every 3 cycles.
- `id_ready`=0 for 5 cycles -> `count` reaches 2, `imem_req` drops, `id_instr`/`id_pc` unchanged; the first pop re-raises `imem_req` the next cycle with no instruction lost or duplicated.
- `redirect` to 0x100 while a 3-wait request at 0x8 is pending -> `imem_addr` stays 0x8 until ack, that data is discarded, the next request is 0x100, and the first `id_pc` after the redirect is 0x100.
- `redirect_pc`=0x203 coincident with an ack and a decode handshake -> acked data dropped, FIFO empty next cycle, next fetch at 0x200; `PC` wrap from 0xFFFFFFFC -> 0x0.
- With `FETCH_PERF_EN`: 10 handshakes and 4 stall cycles -> `perf_fetched`=10, `perf_stall`=4; asserting `rst` mid-run zeroes both counters and `id_valid` immediately.
